charmap_fetch: RTL and testbench

Character-mode video fetch sequencer between the display timer and the character memories. For each 8-pixel cell it sequences one read of char RAM for the character code, one read for the colour attribute, and one read of char ROM for the glyph row. It shifts the row out as a 4-bit colour index, one pixel per pixel-clock enable. It owns port B of char RAM (read-only) and the read port of char ROM; the CPU keeps port A of char RAM.

---
 rtl/charmap_fetch.sv | 109 ++++++++++
 tb/tb_charmap_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/charmap_fetch.sv
// Character-mode fetch sequencer: per 8-pixel cell reads code, attribute and glyph row, then shifts colour out.
// Fetch latency 3 clk_sys cycles from trigger; no backpressure, memories must return data the cycle after the address.
module charmap_fetch #(
  parameter int          COLS      = 40,
  parameter int          ROWS      = 30,
  parameter logic [12:0] CHAR_BASE = 13'h0000,
  parameter logic [12:0] ATTR_BASE = 13'h0800
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        pxl_cen,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic        hblank,
  input  logic        vblank,
  output logic [12:0] chram_addr,
  input  logic [7:0]  chram_q,
  output logic [10:0] chrom_addr,
  input  logic [7:0]  chrom_q,
  output logic [3:0]  colour,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, S_CODE, S_ATTR, S_ROW} state_t;

  state_t      state;
  logic [6:0]  tgt_col;
  logic [5:0]  row;
  logic [12:0] tgt_off;
  logic        trig;
  logic        start;
  logic [12:0] off_q;
  logic [2:0]  line_q;
  logic [7:0]  pend_bmp;
  logic [7:0]  pend_attr;
  logic [7:0]  shifter;
  logic [7:0]  attr_cur;

  // During hblank the next cell to display is column 0 of the upcoming line.
  always_comb begin
    row     = vcnt[8:3];
    tgt_col = hblank ? 7'd0 : {1'b0, hcnt[8:3]} + 7'd1;
    tgt_off = {2'b00, row, 5'b00000} + {4'b0000, row, 3'b000} + {6'b000000, tgt_col};
    trig    = pxl_cen && (hcnt[2:0] == 3'd0);
    start   = trig && (32'(tgt_col) < COLS) && (32'(row) < ROWS) && !vblank;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      chram_addr <= 13'd0;
      chrom_addr <= 11'd0;
      off_q      <= 13'd0;
      line_q     <= 3'd0;
      pend_bmp   <= 8'd0;
      pend_attr  <= 8'd0;
      shifter    <= 8'd0;
      attr_cur   <= 8'd0;
      colour     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            chram_addr <= CHAR_BASE + tgt_off;
            off_q      <= tgt_off;
            line_q     <= vcnt[2:0];
            busy       <= 1'b1;
            state      <= S_CODE;
          end else if (trig) begin
            // Cells outside the text area display as colour 0.
            pend_bmp  <= 8'd0;
            pend_attr <= 8'd0;
          end
        end
        S_CODE: begin
          chram_addr <= ATTR_BASE + off_q;
          chrom_addr <= {chram_q, line_q};
          state      <= S_ATTR;
        end
        S_ATTR: begin
          pend_attr <= chram_q;
          state     <= S_ROW;
        end
        S_ROW: begin
          pend_bmp <= chrom_q;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (pxl_cen) begin
        colour <= (hblank || vblank) ? 4'd0 :
                  (shifter[7] ? attr_cur[7:4] : attr_cur[3:0]);
        if (hcnt[2:0] == 3'd7) begin
          shifter  <= pend_bmp;
          attr_cur <= pend_attr;
        end else begin
          shifter <= {shifter[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_charmap_fetch.sv
// Directed bench for charmap_fetch: behavioural char RAM/ROM, hand-computed colour and address expectations.
module tb_charmap_fetch;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        pxl_cen;
  logic [8:0]  hcnt;
  logic [8:0]  vcnt;
  logic        hblank;
  logic        vblank;
  logic [12:0] chram_addr;
  logic [7:0]  chram_q;
  logic [10:0] chrom_addr;
  logic [7:0]  chrom_q;
  logic [3:0]  colour;
  logic        busy;

  logic [7:0] chram [0:8191];
  logic [7:0] chrom [0:2047];

  int   n_checks = 0;
  int   n_errors = 0;
  logic busy_seen;

  always #5 clk_sys = ~clk_sys;

  assign chram_q = chram[chram_addr];
  assign chrom_q = chrom[chrom_addr];

  charmap_fetch dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pxl_cen    (pxl_cen),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .hblank     (hblank),
    .vblank     (vblank),
    .chram_addr (chram_addr),
    .chram_q    (chram_q),
    .chrom_addr (chrom_addr),
    .chrom_q    (chrom_q),
    .colour     (colour),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel tick, then two idle cycles; busy_seen records any busy in that window.
  task automatic tick(input int h);
    @(negedge clk_sys);
    hcnt    = h[8:0];
    pxl_cen = 1'b1;
    @(negedge clk_sys);
    pxl_cen   = 1'b0;
    busy_seen = busy;
    @(negedge clk_sys);
    busy_seen = busy_seen | busy;
    @(negedge clk_sys);
    busy_seen = busy_seen | busy;
  endtask

  // Eight ticks from h0; seq holds the expected colours, first pixel in the top nibble.
  task automatic check_cell(input string tag, input int h0, input logic [31:0] seq);
    for (int i = 0; i < 8; i++) begin
      tick(h0 + i);
      check($sformatf("%s[%0d]", tag, i), 16'(colour), 16'(seq[31-4*i -: 4]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) chram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) chrom[i] = 8'h00;
    chram[13'h000] = 8'h41;
    chram[13'h800] = 8'h52;
    chrom[11'h208] = 8'hA5;
    chram[13'h029] = 8'h33;
    chram[13'h829] = 8'h7C;
    chram[13'h02A] = 8'h33;
    chram[13'h82A] = 8'h7C;
    chrom[11'h199] = 8'h3C;
    chram[13'h027] = 8'h41;
    chram[13'h827] = 8'h52;
    chram[13'h028] = 8'h41;
    chram[13'h828] = 8'h5F;
    chram[13'h4B0] = 8'h41;
    chram[13'hCB0] = 8'h52;

    reset   = 1'b1;
    pxl_cen = 1'b0;
    hcnt    = 9'd0;
    vcnt    = 9'd0;
    hblank  = 1'b1;
    vblank  = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("rst_colour", 16'(colour), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_chram_addr", 16'(chram_addr), 16'h0);
    check("rst_chrom_addr", 16'(chrom_addr), 16'h0);
    reset = 1'b0;

    // Glyph 0x41 line 0 with attribute 0x52, prefetched in hblank
    vcnt   = 9'd0;
    hblank = 1'b1;
    tick(376);
    tick(383);
    check("hblank_colour", 16'(colour), 16'h0);
    hblank = 1'b0;
    check_cell("glyph", 0, 32'h52522525);

    // Address sequencing for row 1, column 1, glyph line 1
    vcnt = 9'd9;
    @(negedge clk_sys);
    check("addr_busy_pre", 16'(busy), 16'h0);
    hcnt    = 9'd0;
    pxl_cen = 1'b1;
    @(negedge clk_sys);
    pxl_cen = 1'b0;
    check("addr_code", 16'(chram_addr), 16'h0029);
    check("addr_busy1", 16'(busy), 16'h1);
    @(negedge clk_sys);
    check("addr_attr", 16'(chram_addr), 16'h0829);
    check("addr_rom", 16'(chrom_addr), 16'h0199);
    check("addr_busy2", 16'(busy), 16'h1);
    @(negedge clk_sys);
    check("addr_busy3", 16'(busy), 16'h1);
    @(negedge clk_sys);
    check("addr_busy4", 16'(busy), 16'h0);
    tick(7);
    check_cell("addr_glyph", 8, 32'hCC7777CC);

    // Reset while the fetch sits in S_ATTR
    @(negedge clk_sys);
    hcnt    = 9'd0;
    pxl_cen = 1'b1;
    @(negedge clk_sys);
    pxl_cen = 1'b0;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("abort_colour", 16'(colour), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_chram_addr", 16'(chram_addr), 16'h0);
    check("abort_chrom_addr", 16'(chrom_addr), 16'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    tick(7);
    tick(8);
    check("abort_pending", 16'(colour), 16'h0);
    tick(0);
    tick(7);
    check_cell("abort_glyph", 8, 32'hCC7777CC);

    // Column 39 fetched, column 40 skipped
    vcnt   = 9'd0;
    hblank = 1'b0;
    tick(304);
    tick(311);
    tick(312);
    check("col39_px0", 16'(colour), 16'h5);
    check("lastcol_busy", 16'(busy_seen), 16'h0);
    tick(319);
    check_cell("col40", 320, 32'h0);

    // Text row 30 is out of range
    hblank = 1'b1;
    tick(368);
    vcnt = 9'd240;
    tick(376);
    check("row240_busy", 16'(busy_seen), 16'h0);
    tick(383);
    hblank = 1'b0;
    check_cell("row240", 0, 32'h0);

    // Vertical blank suppresses the fetch
    vcnt   = 9'd0;
    hblank = 1'b1;
    tick(368);
    vblank = 1'b1;
    tick(376);
    check("vblank_busy", 16'(busy_seen), 16'h0);
    tick(383);
    hblank = 1'b0;
    check_cell("vblank", 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
